// File: rtl/jttrack_sndlatch.sv
// Main-to-sound command latch: small FIFO for bytes written by the main CPU,
// edge-triggered sound CPU IRQ and a rising-edge pop for the sound CPU's reads.
module jttrack_sndlatch #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [7:0]    main_dout,
  input  logic          m2s_data,
  input  logic          m2s_irq,
  input  logic          rd,
  input  logic          irq_ack,
  output logic [7:0]    dout,
  output logic          irqn,
  output logic [AW:0]   level,
  output logic          ovf
);

  localparam int          DEPTH = 1 << AW;
  localparam int          PW    = (AW > 0) ? AW : 1;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    last_q;
  logic          armed;
  logic          data_l, irq_l, rd_l;

  logic          wr_rise, irq_rise, rd_rise;
  logic          empty, full, do_pop, overwrite, grow;
  logic          mem_we;
  logic [PW-1:0] mem_wa;
  logic [AW:0]   level_nxt;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_prev(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p - 1'b1;
  endfunction

  // The first cycle after reset only loads the edge registers, so inputs
  // already high at release are not mistaken for edges.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_rise   = armed & m2s_data & ~data_l;
    irq_rise  = armed & m2s_irq & ~irq_l;
    rd_rise   = armed & cen & rd & ~rd_l;
    empty     = (level == '0);
    full      = (level == FULL);
    do_pop    = rd_rise & ~empty;
    overwrite = wr_rise & full & ~do_pop;
    grow      = wr_rise & ~overwrite;
    mem_we    = wr_rise & ~rst;
    mem_wa    = overwrite ? ptr_prev(wr_ptr) : wr_ptr;
    level_nxt = level;
    case ({grow, do_pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // NOTE: the storage array has no reset; clearing level is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= main_dout;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
    if (rst) begin
      armed  <= 1'b0;
      data_l <= 1'b0;
      irq_l  <= 1'b0;
      rd_l   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      last_q <= 8'h00;
      ovf    <= 1'b0;
      irqn   <= 1'b1;
    end else begin
      armed  <= 1'b1;
      data_l <= m2s_data;
      irq_l  <= m2s_irq;
      if (cen || !armed) rd_l <= rd;
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
        last_q <= mem[rd_ptr];
      end
      if (grow)      wr_ptr <= ptr_next(wr_ptr);
      if (overwrite) ovf    <= 1'b1;
      level <= level_nxt;
      if (irq_rise)            irqn <= 1'b0;
      else if (cen && irq_ack) irqn <= 1'b1;
    end
  end

  // When empty, the last popped byte stays on the bus.
  assign dout = empty ? last_q : mem[rd_ptr];

endmodule

// File: tb/tb_jttrack_sndlatch.sv
// Self-checking bench for jttrack_sndlatch (AW=2): a queue model of the FIFO
// supplies the expected byte for every pop, plus IRQ and boundary checks.
module tb_jttrack_sndlatch;

  logic       clk = 1'b0;
  logic       rst, cen;
  logic [7:0] main_dout;
  logic       m2s_data, m2s_irq, rd, irq_ack;
  logic [7:0] dout;
  logic       irqn;
  logic [2:0] level;
  logic       ovf;

  jttrack_sndlatch #(.AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .main_dout (main_dout),
    .m2s_data  (m2s_data),
    .m2s_irq   (m2s_irq),
    .rd        (rd),
    .irq_ack   (irq_ack),
    .dout      (dout),
    .irqn      (irqn),
    .level     (level),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] sb[$];
  logic [7:0] last_out = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    main_dout = d;
    m2s_data  = 1'b1;
    tick();
    m2s_data  = 1'b0;
    tick();
    if (sb.size() == 4) sb[$] = d;
    else sb.push_back(d);
  endtask

  task automatic pop_byte(input string tag);
    check({tag, "_dout"}, dout, (sb.size() > 0) ? sb[0] : last_out);
    cen = 1'b1;
    rd  = 1'b1;
    tick();
    rd  = 1'b0;
    tick();
    if (sb.size() > 0) last_out = sb.pop_front();
    check({tag, "_level"}, level, sb.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    last_out = 8'h00;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cen = 1'b1; main_dout = 8'h00;
    m2s_data = 1'b1; m2s_irq = 1'b0; rd = 1'b0; irq_ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tick();
    // strobe held high across reset release must not count as a write
    check("rst_level", level, 0);
    check("rst_dout", dout, 8'h00);
    check("rst_irqn", irqn, 1);
    check("rst_ovf", ovf, 0);
    m2s_data = 1'b0;
    tick();

    // single write then pop
    wr_byte(8'h5A);
    check("t1_level", level, 1);
    check("t1_dout", dout, 8'h5A);
    pop_byte("t1_pop");
    check("t1_hold", dout, 8'h5A);
    check("t1_irqn", irqn, 1);

    // fill, overflow onto newest entry, drain
    for (int i = 0; i < 4; i++) wr_byte(8'h10 + 8'(i));
    check("t2_full", level, 4);
    check("t2_ovf0", ovf, 0);
    wr_byte(8'h99);
    check("t2_level", level, 4);
    check("t2_ovf1", ovf, 1);
    for (int i = 0; i < 4; i++) pop_byte("t2_pop");

    // rd rise without cen is ignored
    wr_byte(8'h42);
    cen = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    cen = 1'b1;
    tick();
    check("rd_nocen", level, 1);
    pop_byte("t2b_pop");

    // irq set, ack gated by cen
    m2s_irq = 1'b1;
    tick();
    check("t3_irq", irqn, 0);
    cen = 1'b0; irq_ack = 1'b1;
    tick();
    check("t3_ack_nocen", irqn, 0);
    cen = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("t3_ack", irqn, 1);
    repeat (5) tick();
    check("t3_held", irqn, 1);

    // trigger wins over same-cycle ack; held level does not retrigger
    m2s_irq = 1'b0;
    tick();
    m2s_irq = 1'b1; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("t4_both", irqn, 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("t4_ack", irqn, 1);
    repeat (4) tick();
    check("t4_noretrig", irqn, 1);
    m2s_irq = 1'b0;

    // simultaneous write and pop on a full FIFO
    do_reset();
    check("t5_ovf_rst", ovf, 0);
    for (int i = 0; i < 4; i++) wr_byte(8'hA0 + 8'(i));
    check("t5_full", level, 4);
    check("t5_head", dout, sb[0]);
    main_dout = 8'h77; m2s_data = 1'b1; rd = 1'b1; cen = 1'b1;
    tick();
    m2s_data = 1'b0; rd = 1'b0;
    tick();
    last_out = sb.pop_front();
    sb.push_back(8'h77);
    check("t5_ovf", ovf, 0);
    check("t5_level", level, 4);
    for (int i = 0; i < 4; i++) pop_byte("t5_pop");

    // pop on empty, then reset with data and IRQ pending
    pop_byte("t6_empty");
    check("t6_hold", dout, 8'h77);
    for (int i = 0; i < 3; i++) wr_byte(8'hB0 + 8'(i));
    m2s_irq = 1'b1;
    tick();
    m2s_irq = 1'b0;
    check("t6_irq", irqn, 0);
    check("t6_level3", level, 3);
    do_reset();
    check("t6_rst_level", level, 0);
    check("t6_rst_irqn", irqn, 1);
    check("t6_rst_dout", dout, 8'h00);
    wr_byte(8'hC3);
    pop_byte("t6_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
